ram_port_arbiter: RTL and testbench

- Shares the single program/data RAM between the CPU datapath (strobes driven by the control sequencer) and an external program loader.
- Sits between the MAR/RAM strobes and the RAM macro.
- Loader gets exclusive, burst-limited ownership via a req/gnt/stb/ack handshake. While the loader owns the RAM, the CPU is frozen through cpu_stall.
- A minimum CPU dwell guarantees forward progress of the CPU between loader bursts.

---
 rtl/ram_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares the single program/data RAM between the CPU datapath and an external
// program loader. The CPU normally owns the RAM, and its strobes pass straight
// through to the macro. The loader asks for ownership with a level request.
// It gets an exclusive grant once the CPU is idle and its dwell time has run
// out. The grant ends after MAX_BURST strobes or when the request drops. A
// one-cycle RETURN state then lets the last ack drain before the CPU takes the
// RAM back for at least MIN_CPU_CYCLES unstalled cycles.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   cpu_ce_n/we_n         CPU RAM enable / write strobes (active-low)
//   cpu_addr/cpu_wdata    CPU address (from MAR) and write data
//   cpu_stall             CPU must hold its stage while high
//   cpu_drop              sticky flag: CPU strobed while it did not own the RAM
//   ldr_req               loader ownership request (level)
//   ldr_stb/we/addr/wdata loader access, one access per cycle while ldr_stb=1
//   ldr_gnt               loader owns the RAM
//   ldr_ack/ldr_rdata     one-cycle completion pulse and the captured read data
//   ram_*                 RAM macro interface; ram_rdata is combinational
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int MAX_BURST      = 8,
  parameter int MIN_CPU_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU side
  input  logic              cpu_ce_n,
  input  logic              cpu_we_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_drop,
  // Loader side
  input  logic              ldr_req,
  input  logic              ldr_stb,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  // RAM macro
  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int DWELL_W = $clog2(MIN_CPU_CYCLES + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(MIN_CPU_CYCLES);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST);

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    LDR_OWN = 2'd1,
    RETURN  = 2'd2
  } state_e;

  state_e              state_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [BURST_W-1:0]  burst_q;
  logic [BURST_W-1:0]  burst_d;
  logic                ldr_gnt_q;
  logic                ldr_ack_q;
  logic [DATA_W-1:0]   ldr_rdata_q;
  logic                cpu_drop_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic [DATA_W-1:0]   last_wdata_q;

  logic cpu_strobe;
  logic dwell_zero;
  logic burst_done;
  logic stall_raw;

  assign cpu_strobe = ~cpu_ce_n | ~cpu_we_n;
  assign dwell_zero = (dwell_q == '0);
  assign burst_d    = burst_q + BURST_W'(1);
  // The strobe being served right now is the last one this grant allows.
  assign burst_done = (burst_d == BURST_LAST);

  // RAM steering and stall. The CPU path is a pure pass-through so CPU timing
  // through the arbiter is unchanged; loader accesses are likewise
  // combinational, with the response registered one cycle later.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would otherwise infer a latch.
    ram_ce_n  = 1'b1;
    ram_we_n  = 1'b1;
    ram_addr  = last_addr_q;
    ram_wdata = last_wdata_q;
    stall_raw = 1'b1;
    unique case (state_q)
      CPU_OWN: begin
        ram_ce_n  = cpu_ce_n;
        ram_we_n  = cpu_we_n;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        // Freeze the sequencer as soon as a handover is due, so it stops
        // issuing strobes and the idle cycle needed for the grant appears.
        stall_raw = ldr_req & dwell_zero;
      end
      LDR_OWN: begin
        if (ldr_stb) begin
          ram_ce_n  = 1'b0;
          ram_we_n  = ~ldr_we;
          ram_addr  = ldr_addr;
          ram_wdata = ldr_wdata;
        end
      end
      default: ;
    endcase
  end

  // Reset releases the CPU at once, even when a loader request is still up.
  assign cpu_stall = rst_n & stall_raw;

  // Single-process FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CPU_OWN;
      dwell_q      <= '0;
      burst_q      <= '0;
      ldr_gnt_q    <= 1'b0;
      ldr_ack_q    <= 1'b0;
      ldr_rdata_q  <= '0;
      cpu_drop_q   <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      ldr_ack_q <= 1'b0;

      // A CPU strobe outside CPU_OWN never reaches the RAM; remember it.
      if (state_q != CPU_OWN && cpu_strobe) begin
        cpu_drop_q <= 1'b1;
      end

      unique case (state_q)
        CPU_OWN: begin
          // Hand over only on an idle CPU cycle; a CPU access is never cut.
          if (ldr_req && dwell_zero && !cpu_strobe) begin
            state_q   <= LDR_OWN;
            ldr_gnt_q <= 1'b1;
            burst_q   <= '0;
          end else if (!dwell_zero) begin
            dwell_q <= dwell_q - DWELL_W'(1);
          end
        end

        LDR_OWN: begin
          if (ldr_stb) begin
            ldr_ack_q    <= 1'b1;
            ldr_rdata_q  <= ram_rdata;
            burst_q      <= burst_d;
            last_addr_q  <= ldr_addr;
            last_wdata_q <= ldr_wdata;
          end
          // A strobe in the same cycle as the release is still served above.
          if (!ldr_req || (ldr_stb && burst_done)) begin
            state_q   <= RETURN;
            ldr_gnt_q <= 1'b0;
          end
        end

        RETURN: begin
          state_q <= CPU_OWN;
          dwell_q <= DWELL_INIT;
        end

        default: state_q <= CPU_OWN;
      endcase
    end
  end

  assign ldr_gnt   = ldr_gnt_q;
  assign ldr_ack   = ldr_ack_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cpu_drop  = cpu_drop_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Self-checking bench for ram_port_arbiter. It provides a behavioural RAM
// macro, a table of pass-through vectors, hand-written sequences for handover,
// burst limit, dwell, drop and asynchronous reset, and a randomized phase
// checked against a cycle model built from the ownership rules.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int ADDR_W         = 4;
  localparam int DATA_W         = 8;
  localparam int MAX_BURST      = 8;
  localparam int MIN_CPU_CYCLES = 6;
  localparam int DEPTH          = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_ce_n, cpu_we_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall, cpu_drop;
  logic              ldr_req, ldr_stb, ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt, ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ram_ce_n, ram_we_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST), .MIN_CPU_CYCLES(MIN_CPU_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ce_n(cpu_ce_n), .cpu_we_n(cpu_we_n), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_drop(cpu_drop),
    .ldr_req(ldr_req), .ldr_stb(ldr_stb), .ldr_we(ldr_we),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM macro: combinational read, write on the rising edge.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state for the randomized phase.
  bit                m_owns, m_ret, m_ack, m_drop;
  int                m_dwell, m_served;
  logic [DATA_W-1:0] m_rdata;
  logic [DATA_W-1:0] m_mem [DEPTH];

  task automatic idle_inputs();
    cpu_ce_n = 1'b1; cpu_we_n = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_stb = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic init_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   = DATA_W'(i * 37 + 5);
      m_mem[i] = DATA_W'(i * 37 + 5);
    end
  endtask

  // Reset is released between edges; returns just after the first live edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    next_cycle();
  endtask

  typedef struct {
    logic              ce_n, we_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              stb, lwe;
    logic [ADDR_W-1:0] laddr;
    logic              e_ce_n, e_we_n;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int acks;
    vecs[0] = '{1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h3, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 4'h5, 8'h3C, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 8'h3C};
    vecs[2] = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 1'b1, 4'h9, 1'b1, 1'b1, 4'h0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 4'h5, 8'h00, 1'b1, 1'b0, 4'h9, 1'b0, 1'b1, 4'h5, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 4'hF, 8'h81, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 8'h81};
    vecs[5] = '{1'b1, 1'b1, 4'hA, 8'h55, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hA, 8'h55};

    idle_inputs();
    init_mem();
    rst_n = 1'b1;
    #2;
    apply_reset();

    // Reset state
    settle();
    check("rst_gnt", ldr_gnt, 0);
    check("rst_ack", ldr_ack, 0);
    check("rst_rdata", ldr_rdata, 0);
    check("rst_drop", cpu_drop, 0);
    check("rst_stall", cpu_stall, 0);
    next_cycle();

    // CPU pass-through vectors; loader strobes without a grant are ignored.
    for (int v = 0; v < 6; v++) begin
      cpu_ce_n = vecs[v].ce_n; cpu_we_n = vecs[v].we_n;
      cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
      ldr_stb = vecs[v].stb; ldr_we = vecs[v].lwe; ldr_addr = vecs[v].laddr;
      ldr_wdata = 8'hFF;
      settle();
      check($sformatf("vec%0d_ce_n", v), ram_ce_n, vecs[v].e_ce_n);
      check($sformatf("vec%0d_we_n", v), ram_we_n, vecs[v].e_we_n);
      check($sformatf("vec%0d_addr", v), ram_addr, vecs[v].e_addr);
      check($sformatf("vec%0d_wdata", v), ram_wdata, vecs[v].e_wdata);
      check($sformatf("vec%0d_stall", v), cpu_stall, 0);
      check($sformatf("vec%0d_gnt", v), ldr_gnt, 0);
      check($sformatf("vec%0d_ack", v), ldr_ack, 0);
      next_cycle();
    end
    idle_inputs();

    // Request arrives while the CPU reads for two cycles: stall at once,
    // grant only after the first idle CPU cycle.
    cpu_ce_n = 1'b0; cpu_addr = 4'h3; ldr_req = 1'b1;
    settle();
    check("hand_c1_stall", cpu_stall, 1);
    check("hand_c1_ce_n", ram_ce_n, 0);
    check("hand_c1_addr", ram_addr, 4'h3);
    check("hand_c1_gnt", ldr_gnt, 0);
    next_cycle();
    settle();
    check("hand_c2_stall", cpu_stall, 1);
    check("hand_c2_ce_n", ram_ce_n, 0);
    check("hand_c2_gnt", ldr_gnt, 0);
    next_cycle();
    cpu_ce_n = 1'b1;
    settle();
    check("hand_idle_gnt", ldr_gnt, 0);
    check("hand_idle_stall", cpu_stall, 1);
    next_cycle();

    // Loader write A5 -> 7, then read 7 back.
    ldr_stb = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h7; ldr_wdata = 8'hA5;
    settle();
    check("wr_gnt", ldr_gnt, 1);
    check("wr_stall", cpu_stall, 1);
    check("wr_ce_n", ram_ce_n, 0);
    check("wr_we_n", ram_we_n, 0);
    check("wr_addr", ram_addr, 4'h7);
    check("wr_wdata", ram_wdata, 8'hA5);
    check("wr_ack_early", ldr_ack, 0);
    next_cycle();
    ldr_we = 1'b0; ldr_wdata = 8'h00;
    settle();
    check("rd_ack_of_wr", ldr_ack, 1);
    check("rd_ce_n", ram_ce_n, 0);
    check("rd_we_n", ram_we_n, 1);
    check("rd_addr", ram_addr, 4'h7);
    next_cycle();
    ldr_stb = 1'b0; ldr_req = 1'b0;
    settle();
    check("rd_ack", ldr_ack, 1);
    check("rd_rdata", ldr_rdata, 8'hA5);
    check("rd_gnt_held", ldr_gnt, 1);
    check("idle_ce_n", ram_ce_n, 1);
    next_cycle();
    settle();
    check("ret_gnt", ldr_gnt, 0);
    check("ret_stall", cpu_stall, 1);
    check("ret_ack", ldr_ack, 0);
    check("ret_ce_n", ram_ce_n, 1);
    next_cycle();
    settle();
    check("back_stall", cpu_stall, 0);
    check("back_rdata_hold", ldr_rdata, 8'hA5);

    // Let the dwell expire, then a held request with 10 back-to-back strobes.
    repeat (8) next_cycle();
    ldr_req = 1'b1;
    settle();
    check("burst_pre_stall", cpu_stall, 1);
    check("burst_pre_gnt", ldr_gnt, 0);
    next_cycle();
    acks = 0;
    for (int c = 0; c < 16; c++) begin
      ldr_stb = (c < 10); ldr_we = 1'b1;
      ldr_addr = ADDR_W'(c); ldr_wdata = DATA_W'(8'h10 + c);
      settle();
      check($sformatf("burst_c%0d_gnt", c), ldr_gnt, (c < 8));
      check($sformatf("burst_c%0d_ack", c), ldr_ack, (c >= 1 && c <= 8));
      check($sformatf("burst_c%0d_stall", c), cpu_stall, !(c >= 9 && c <= 14));
      check($sformatf("burst_c%0d_ce_n", c), ram_ce_n, !(c < 8));
      acks += int'(ldr_ack);
      next_cycle();
    end
    check("burst_ack_count", acks, MAX_BURST);

    // Re-granted: a CPU write forced now must not reach the RAM.
    ldr_stb = 1'b0;
    cpu_ce_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 4'h2; cpu_wdata = 8'hEE;
    settle();
    check("regrant_gnt", ldr_gnt, 1);
    check("drop_ce_n", ram_ce_n, 1);
    check("drop_we_n", ram_we_n, 1);
    check("drop_before", cpu_drop, 0);
    next_cycle();
    idle_inputs();
    settle();
    check("drop_set", cpu_drop, 1);
    next_cycle();
    settle();
    check("drop_sticky_ret", cpu_drop, 1);
    repeat (8) next_cycle();
    settle();
    check("drop_sticky_cpu", cpu_drop, 1);

    // Asynchronous reset in the middle of a burst, with an ack in flight.
    next_cycle();
    ldr_req = 1'b1;
    next_cycle();
    ldr_stb = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h1; ldr_wdata = 8'h77;
    next_cycle();
    ldr_addr = 4'h2; ldr_wdata = 8'h78;
    settle();
    check("arst_pre_gnt", ldr_gnt, 1);
    check("arst_pre_ack", ldr_ack, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_gnt", ldr_gnt, 0);
    check("arst_ack", ldr_ack, 0);
    check("arst_stall", cpu_stall, 0);
    check("arst_drop", cpu_drop, 0);
    check("arst_rdata", ldr_rdata, 0);
    @(posedge clk);
    #1;
    check("arst_noack", ldr_ack, 0);
    idle_inputs();
    #3 rst_n = 1'b1;
    settle();
    check("arst_rel_gnt", ldr_gnt, 0);
    check("arst_rel_ack", ldr_ack, 0);
    next_cycle();

    // Randomized phase against the ownership model.
    idle_inputs();
    init_mem();
    apply_reset();
    m_owns = 0; m_ret = 0; m_ack = 0; m_drop = 0;
    m_dwell = 0; m_served = 0; m_rdata = '0;
    for (int n = 0; n < 600; n++) begin
      bit cpu_phase, e_ce_n, e_we_n, e_stall, e_gnt, cpu_str, nxt_ack;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      cpu_phase = !m_owns && !m_ret;
      if (cpu_phase && $urandom_range(0, 9) < 3) begin
        cpu_ce_n = 1'b0;
        cpu_we_n = 1'($urandom_range(0, 1));
      end else begin
        cpu_ce_n = 1'b1;
        cpu_we_n = 1'b1;
      end
      cpu_addr  = ADDR_W'($urandom);
      cpu_wdata = DATA_W'($urandom);
      if ($urandom_range(0, 9) < 2) ldr_req = ~ldr_req;
      ldr_stb   = 1'($urandom_range(0, 1));
      ldr_we    = 1'($urandom_range(0, 1));
      ldr_addr  = ADDR_W'($urandom);
      ldr_wdata = DATA_W'($urandom);

      // Expected combinational view of this cycle.
      e_ce_n = 1; e_we_n = 1; e_addr = '0; e_wdata = '0; e_stall = 1; e_gnt = 0;
      if (cpu_phase) begin
        e_ce_n = cpu_ce_n; e_we_n = cpu_we_n; e_addr = cpu_addr; e_wdata = cpu_wdata;
        e_stall = ldr_req && (m_dwell == 0);
      end else if (m_owns) begin
        e_gnt = 1;
        if (ldr_stb) begin
          e_ce_n = 0; e_we_n = !ldr_we; e_addr = ldr_addr; e_wdata = ldr_wdata;
        end
      end

      settle();
      check("rnd_ce_n", ram_ce_n, e_ce_n);
      check("rnd_we_n", ram_we_n, e_we_n);
      if (cpu_phase || !e_ce_n) begin
        check("rnd_addr", ram_addr, e_addr);
        check("rnd_wdata", ram_wdata, e_wdata);
      end
      check("rnd_stall", cpu_stall, e_stall);
      check("rnd_gnt", ldr_gnt, e_gnt);
      check("rnd_ack", ldr_ack, m_ack);
      check("rnd_rdata", ldr_rdata, m_rdata);
      check("rnd_drop", cpu_drop, m_drop);

      @(posedge clk);
      // Advance the model over this edge.
      cpu_str = !cpu_ce_n || !cpu_we_n;
      if (!cpu_phase && cpu_str) m_drop = 1;
      if (cpu_phase && !cpu_ce_n && !cpu_we_n) m_mem[cpu_addr] = cpu_wdata;
      nxt_ack = m_owns && ldr_stb;
      if (nxt_ack) begin
        m_rdata = m_mem[ldr_addr];
        if (ldr_we) m_mem[ldr_addr] = ldr_wdata;
      end
      m_ack = nxt_ack;
      if (cpu_phase) begin
        if (ldr_req && m_dwell == 0 && !cpu_str) begin
          m_owns = 1; m_served = 0;
        end else if (m_dwell > 0) begin
          m_dwell--;
        end
      end else if (m_owns) begin
        if (ldr_stb) m_served++;
        if (!ldr_req || m_served == MAX_BURST) begin
          m_owns = 0; m_ret = 1;
        end
      end else begin
        m_ret = 0; m_dwell = MIN_CPU_CYCLES;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
